// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the add-shift multiplier control stage.
//   N_BITS  : operand width, also the number of add/shift iterations
//   A_W     : width of the X:A accumulator (sign bit plus 8-bit A)
//   CNT_W   : width of the iteration counter
//   state_t : controller states
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int N_BITS = 8;
    localparam int A_W    = 9;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLRLD,
        CLR,
        ADD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/adder9.sv
// -----------------------------------------------------------------------------
// adder9
// 9-bit adder/subtractor for the X:A accumulator. When sub is high the result
// is a - b in two's complement. Inverting b and feeding sub in as the carry-in
// means one adder serves both operations. The result wraps modulo 2^9.
// Ports:
//   a   in  [8:0]  accumulator operand {X, A}
//   b   in  [8:0]  sign-extended multiplicand
//   sub in         1 = subtract b, 0 = add b
//   sum out [8:0]  result, modulo 2^9
// -----------------------------------------------------------------------------
module adder9
    import mult_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    input  logic           sub,
    output logic [A_W-1:0] sum
);

    logic [A_W-1:0] w_b_inv;
    logic [A_W-1:0] w_cin;

    assign w_b_inv = b ^ {A_W{sub}};
    assign w_cin   = {{(A_W-1){1'b0}}, sub};
    assign sum     = a + w_b_inv + w_cin;

endmodule

// File: rtl/mult_ctrl_unit.sv
// -----------------------------------------------------------------------------
// mult_ctrl_unit
// Sequencer and arithmetic stage for an 8-bit signed add-shift multiplier.
// Drives the load/clear/shift strobes of an external X:A:B register unit and
// computes the next X:A value. The last iteration subtracts the multiplicand
// because the multiplier's MSB carries negative weight.
//
// Optional build macro:
//   MULT_SKIP_ZERO_EN - bypass ADD whenever the multiplier bit is 0.
//
// Ports:
//   Clk          in        clock, rising edge
//   Reset_n      in        asynchronous active-low reset
//   Run          in        level start request
//   ClearA_LoadB in        clear X:A and load B from S (IDLE only)
//   S            in  [7:0] signed multiplicand
//   Data_Out     in [15:0] register unit {A, B}; M = Data_Out[0]
//   X            in        sign-extension bit above A
//   A_sum        out [8:0] next {X, A} value
//   Load_a       out       load {X, A} from A_sum
//   clr_ld       out       clear X:A, load B from S
//   Shift_En     out       arithmetic right shift of X:A:B
//   cleara       out       clear X:A only
//   Busy         out       run in progress (CLR through last SHIFT)
//   Done         out       product valid, waiting for Run to drop
// -----------------------------------------------------------------------------
module mult_ctrl_unit
    import mult_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Run,
    input  logic           ClearA_LoadB,
    input  logic [7:0]     S,
    input  logic [15:0]    Data_Out,
    input  logic           X,
    output logic [A_W-1:0] A_sum,
    output logic           Load_a,
    output logic           clr_ld,
    output logic           Shift_En,
    output logic           cleara,
    output logic           Busy,
    output logic           Done
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_m;
    logic [A_W-1:0]   w_a;
    logic [A_W-1:0]   w_s;
    logic             w_unused_b;

    assign w_m    = Data_Out[0];
    assign w_last = (r_cnt == CNT_W'(N_BITS - 1));
    assign w_a    = {X, Data_Out[15:8]};
    assign w_s    = {S[7], S};

    // Bit 1 is only consulted by the skip-zero build; the rest of B is
    // never looked at by the controller.
    assign w_unused_b = ^Data_Out[7:1];

    adder9 u_adder9 (
        .a   (w_a),
        .b   (w_s),
        .sub (w_last),
        .sum (A_sum)
    );

    // NOTE: state and counter use non-blocking assignments so every register
    // updates from values sampled before the edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == CLR) begin
                r_cnt <= '0;
            end else if (r_state == SHIFT && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next   = r_state;
        Load_a   = 1'b0;
        clr_ld   = 1'b0;
        Shift_En = 1'b0;
        cleara   = 1'b0;

        case (r_state)
            IDLE: begin
                if (ClearA_LoadB) begin
                    w_next = CLRLD;
                end else if (Run) begin
                    w_next = CLR;
                end
            end
            CLRLD: begin
                clr_ld = 1'b1;
                w_next = IDLE;
            end
            CLR: begin
                cleara = 1'b1;
`ifdef MULT_SKIP_ZERO_EN
                w_next = w_m ? ADD : SHIFT;
`else
                w_next = ADD;
`endif
            end
            ADD: begin
                Load_a = w_m;
                w_next = SHIFT;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end else begin
`ifdef MULT_SKIP_ZERO_EN
                    // B has not shifted yet, so the next iteration's
                    // multiplier bit is still sitting in Data_Out[1].
                    w_next = Data_Out[1] ? ADD : SHIFT;
`else
                    w_next = ADD;
`endif
                end
            end
            DONE: begin
                if (!Run) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign Busy = (r_state == CLR) || (r_state == ADD) || (r_state == SHIFT);
    assign Done = (r_state == DONE);

endmodule

// File: doc/mult_ctrl_unit.md
# mult_ctrl_unit

Control and arithmetic stage directly upstream of the multiplier register unit. It sequences the 8-bit signed add-shift multiply and computes the 9-bit sum or difference that is loaded into the A/X register. It drives that unit's load, clear and shift strobes and reads back its product bus and X bit. One run takes a fixed or variable number of cycles, depending on configuration, and then holds the product until Run is released.

## Interface
- N_BITS, 8: multiplicand/multiplier width. Iteration count equals N_BITS.
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Run  in  1  level start request.
- ClearA_LoadB  in  1  level request to clear A/X and load B from S.
- S  in  8  multiplicand (signed), from switches.
- Data_Out  in  16  product bus from register unit: A = [15:8], B = [7:0]. M is Data_Out[0].
- X  in  1  sign-extension bit of A from register unit.
- A_sum  out  9  next A/X value, goes to the register unit's 9-bit A input.
- Load_a  out  1  load A/X with A_sum.
- clr_ld  out  1  clear A/X and load B with S.
- Shift_En  out  1  arithmetic right shift of X:A:B.
- cleara  out  1  clear A/X only.
- Busy  out  1  high from CLR through the last SHIFT state.
- Done  out  1  high in DONE.

## Operation
- States: IDLE, CLRLD, CLR, ADD, SHIFT, DONE. A 3-bit iteration counter cnt runs 0..N_BITS-1.
- IDLE:
  - If ClearA_LoadB = 1, go to CLRLD. ClearA_LoadB has priority over Run.
  - Else if Run = 1, go to CLR.
- CLRLD: clr_ld = 1 for one cycle, then IDLE.
- CLR: cleara = 1 and cnt <= 0, then ADD.
- ADD: Load_a = M (Mealy output), then SHIFT.
- SHIFT: Shift_En = 1.
  - If cnt = N_BITS-1, go to DONE.
  - Else cnt <= cnt+1 and go to ADD.
- DONE: no strobes. Stay while Run = 1; go to IDLE when Run = 0.
- ClearA_LoadB is ignored outside IDLE. Run is level-sensitive, so Run held high through reset starts a run immediately after reset.
- Arithmetic:
  - Operand a = {X, Data_Out[15:8]}. Operand s = {S[7], S}, the sign extension of S.
  - A_sum = a + s when cnt < N_BITS-1.
  - A_sum = a + ~s + 1 (subtract) when cnt = N_BITS-1.
  - Result is modulo 2^9; there is no overflow flag.
  - A_sum is combinational and valid every cycle. It is only meaningful when Load_a = 1.
- Strobes are mutually exclusive: at most one of Load_a, clr_ld, Shift_En, cleara is high in any cycle.

## Timing
- Reset (Reset_n low, asynchronous):
  - state = IDLE, cnt = 0.
  - All strobes, Busy and Done are 0.
- Reset mid-run: return to IDLE at once. Register-unit contents are left as they are (partial product). Done stays 0.
- Run sampled high in IDLE at edge 0 gives this sequence:
  - CLR during cycle 1.
  - ADD/SHIFT pairs during cycles 2..17.
  - DONE from cycle 18.
  - Product is valid on Data_Out when Done = 1.
- Strobe decode is combinational from state (and M for Load_a). The register unit acts on the same edge that leaves the state.
- M is read in ADD, after the previous SHIFT edge has updated B.

## Configuration
- MULT_SKIP_ZERO_EN:
  - Defined: when M = 0 the ADD state is bypassed. Both the SHIFT-to-next-iteration path and the CLR exit go straight to SHIFT. Run length is 2 + N_BITS + popcount-dependent ADD cycles, and DONE is reached between cycle 10 and cycle 18.
  - Undefined: every iteration visits ADD, so DONE is always reached at cycle 18.

## Structure
- Package mult_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, CLRLD, CLR, ADD, SHIFT, DONE}.
  - localparam N_BITS = 8.
  - localparam A_W = 9.
- Sub-module adder9: 9-bit adder/subtractor with inputs a, b and sub, and output sum. Subtraction is implemented as b XOR sub plus carry-in sub. It is instantiated once in mult_ctrl_unit.

## Test plan
- Reset then ClearA_LoadB pulse with S = 0x03: clr_ld high for exactly 1 cycle, back in IDLE, register unit B = 0x03.
- S = 0x07, B = 0x03, Run held high: Done at cycle 18 (skip-zero off), Data_Out = 0x0015. Release Run: IDLE the next cycle.
- S = 0xF9 (-7), B = 0x03: Data_Out = 0xFFEB. Also S = 0x07, B = 0xFD (-3): Data_Out = 0xFFEB, with the final ADD subtracting.
- S = 0x80, B = 0x80: Data_Out = 0x4000. S = 0x7F, B = 0x80: Data_Out = 0xC080.
- Reset_n pulsed low during iteration 4: all outputs 0 immediately, state IDLE, no further strobes until the next Run.
- With MULT_SKIP_ZERO_EN defined, B = 0x00 and S = 0x55: Load_a never asserted, Done at cycle 10, Data_Out = 0x0000.
